imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter INSTR_MEM_SIZE, default 32, number of 32-bit instruction-memory words.
REQ-002 SHALL have local width AW = ceil(log2(INSTR_MEM_SIZE)) for addresses.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  byte-stream valid.
REQ-006 SHALL have port in_byte  input  8  program byte.
REQ-007 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-008 SHALL have port imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port imem_addr  output  AW  word address of the write.
REQ-010 SHALL have port imem_wdata  output  32  instruction word.
REQ-011 SHALL have port cpu_run  output  1  CPU release; high once load is complete.
REQ-012 SHALL have port error  output  1  sticky load failure.

Function
REQ-013 SHALL accept a byte only on an edge where in_valid and in_ready are both 1.
REQ-014 SHALL implement states IDLE, LOAD, CHECK (macro only), DONE, ERROR.
REQ-015 IDLE: first accepted byte is header N (word count); 1 <= N <= INSTR_MEM_SIZE -> LOAD, else -> ERROR.
REQ-016 LOAD: SHALL assemble bytes big-endian (first byte = bits 31:24) into one word per 4 accepted bytes.
REQ-017 SHALL pulse imem_we for exactly one cycle, registered, in the cycle after the edge accepting a word's 4th byte, with imem_addr/imem_wdata valid in that cycle.
REQ-018 SHALL write words to addresses 0..N-1 in order; address never wraps; no write beyond N-1.
REQ-019 SHALL allow a byte to be accepted in the same cycle imem_we is high (no stall between words).
REQ-020 in_ready SHALL be 1 in IDLE, LOAD, CHECK and 0 in DONE and ERROR.
REQ-021 After final word (or checksum byte with macro), SHALL enter DONE; cpu_run SHALL be 1 from the cycle after the final imem_we pulse (or checksum acceptance).
REQ-022 DONE and ERROR SHALL be terminal until reset; cpu_run stays 0 in ERROR.
REQ-023 ERROR SHALL assert error in the cycle after the offending byte is accepted.
REQ-024 in_valid gaps SHALL only delay progress, never alter written data or addresses.
REQ-025 imem_addr/imem_wdata SHALL hold last values when imem_we is 0.

Reset
REQ-026 reset low at a rising edge SHALL force IDLE, byte counter 0, word counter 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_run 0, error 0, in_ready 1 the following cycle.
REQ-027 Reset mid-word or mid-load SHALL discard the partial word; words already written are not cleared; next accepted byte is a header.

Configuration
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN defined: SHALL keep a running XOR of all 4N payload bytes; after last word enter CHECK, accept one trailer byte; equal -> DONE, unequal -> ERROR.
REQ-029 Macro undefined: no CHECK state, no XOR logic; DONE follows last word directly; port list unchanged.

Verification
REQ-030 N=2, bytes 20 08 00 05 01 09 50 20 (hex) -> writes addr0=0x20080005, addr1=0x01095020; cpu_run=1 one cycle after second imem_we; in_ready=0.
REQ-031 Header 0x00, and separately 0x21 with INSTR_MEM_SIZE=32 -> error=1 next cycle, no imem_we, in_ready=0, cpu_run=0.
REQ-032 N=32 back-to-back with random in_valid bubbles -> 32 single-cycle writes addr 0..31, no wrap, data identical to bubble-free run.
REQ-033 Reset low after header and 2 payload bytes -> all outputs reset values; next stream N=1 12 34 56 78 writes addr0=0x12345678.
REQ-034 Macro on: N=1 12 34 56 78 trailer 08 -> DONE, cpu_run=1; same with trailer 09 -> error=1, cpu_run=0.
REQ-035 Reset low while in DONE -> cpu_run=0, IDLE, new load accepted.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream boot loader: header byte N, then 4N big-endian payload bytes written as N words.
// Optional trailer checksum (running XOR of payload) enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int  INSTR_MEM_SIZE = 32,
  localparam int AW = (INSTR_MEM_SIZE > 1) ? $clog2(INSTR_MEM_SIZE) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_run,
  output logic          error
);

  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] word_cnt;
  logic [CW-1:0] num_words;
  logic [23:0]   acc_p0;
  logic          take;
  logic          last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // A header is a word count between 1 and the memory depth.
  function automatic logic hdr_ok(input logic [7:0] b);
    return (b != 8'd0) && (int'(b) <= INSTR_MEM_SIZE);
  endfunction

  assign take      = in_valid && in_ready;
  assign last_word = (({1'b0, word_cnt} + CW'(1)) == num_words);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      num_words  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
      error      <= 1'b0;
      in_ready   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (take) begin
            if (hdr_ok(in_byte)) begin
              num_words <= CW'(in_byte);
              byte_cnt  <= '0;
              word_cnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum      <= '0;
`endif
              state     <= S_LOAD;
            end else begin
              state    <= S_ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end
          end
        end
        // Byte assembly stage: three bytes held in acc_p0, the fourth completes the word.
        S_LOAD: begin
          if (take) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_byte;
`endif
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt;
              imem_wdata <= {acc_p0, in_byte};
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state    <= S_CHECK;
`else
                state    <= S_DONE;
                in_ready <= 1'b0;
`endif
              end else begin
                word_cnt <= word_cnt + AW'(1);
              end
            end else begin
              acc_p0 <= {acc_p0[15:0], in_byte};
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (take) begin
            in_ready <= 1'b0;
            if (in_byte == csum) begin
              state   <= S_DONE;
              cpu_run <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        // cpu_run rises one cycle after the final write pulse.
        S_DONE: begin
          cpu_run  <= 1'b1;
          in_ready <= 1'b0;
        end
        S_ERROR: begin
          in_ready <= 1'b0;
          cpu_run  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized byte streams checked against a word-list model of the load protocol.
// Define IMEM_LOADER_CHECKSUM_EN for both files to exercise the trailer checksum.
module tb_imem_loader;
  localparam int SIZE = 32;
  localparam int AW   = $clog2(SIZE);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_ready, imem_we, cpu_run, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  imem_loader #(.INSTR_MEM_SIZE(SIZE)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_run(cpu_run), .error(error)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          obs_addr[$];
  logic [31:0] obs_data[$];
  int          last_we_cyc = -1;
  int          run_cyc = -1;
  logic [7:0]  pl[$];
  logic [31:0] ref_words[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      obs_addr.push_back(int'(imem_addr));
      obs_data.push_back(imem_wdata);
      last_we_cyc = cyc;
    end
    if (cpu_run === 1'b1 && run_cyc < 0) run_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    return {pl[4*i], pl[4*i+1], pl[4*i+2], pl[4*i+3]};
  endfunction

  function automatic logic [7:0] exp_csum(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 4*n; i++) x ^= pl[i];
    return x;
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    obs_addr.delete();
    obs_data.delete();
    last_we_cyc = -1;
    run_cyc = -1;
  endtask

  task automatic send(input logic [7:0] b, input bit bub);
    int w;
    if (bub) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        @(posedge clock); #1;
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(posedge clock); #1;
      w++;
    end
    if (in_ready !== 1'b1) begin
      chk("ready_wait", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic load(input int n, input bit bub, output int done_c);
    send(8'(n), bub);
    for (int i = 0; i < 4*n; i++) send(pl[i], bub);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(exp_csum(n), bub);
`endif
    done_c = cyc;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_load(input string tag, input int n, input int done_c);
    chk({tag, "_count"}, obs_addr.size(), n);
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), obs_addr[i], i);
      chk($sformatf("%s_data%0d", tag, i), obs_data[i], exp_word(i));
    end
    chk({tag, "_run"}, {31'd0, cpu_run}, 32'd1);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_err"}, {31'd0, error}, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk({tag, "_runlat"}, run_cyc, done_c);
`else
    chk({tag, "_welat"}, last_we_cyc, done_c);
    chk({tag, "_runlat"}, run_cyc, last_we_cyc + 1);
`endif
  endtask

  task automatic fill_random(input int n);
    pl.delete();
    for (int i = 0; i < 4*n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic bad_header(input logic [7:0] h, input string tag);
    do_reset();
    send(h, 1'b0);
    chk({tag, "_err"}, {31'd0, error}, 32'd1);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_run"}, {31'd0, cpu_run}, 32'd0);
    in_valid = 1'b1;
    in_byte  = 8'h01;
    repeat (6) begin @(posedge clock); #1; end
    in_valid = 1'b0;
    chk({tag, "_nowe"}, obs_addr.size(), 0);
    chk({tag, "_sticky"}, {31'd0, error}, 32'd1);
    chk({tag, "_run2"}, {31'd0, cpu_run}, 32'd0);
  endtask

  initial begin
    int dc, st, n, cnt;

    // Reset state
    do_reset();
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_run", {31'd0, cpu_run}, 32'd0);
    chk("rst_err", {31'd0, error}, 32'd0);

    // Two-word reference program
    pl = {8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    load(2, 1'b0, dc);
    check_load("n2", 2, dc);
    if (obs_data.size() == 2) begin
      chk("n2_w0", obs_data[0], 32'h20080005);
      chk("n2_w1", obs_data[1], 32'h01095020);
    end
    cnt = obs_addr.size();
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    repeat (5) begin @(posedge clock); #1; end
    in_valid = 1'b0;
    chk("done_ignore", obs_addr.size(), cnt);
    chk("done_hold", {31'd0, cpu_run}, 32'd1);
    chk("done_hold_addr", 32'(imem_addr), 32'd1);
    chk("done_hold_data", imem_wdata, 32'h01095020);

    // Illegal headers
    bad_header(8'h00, "hdr00");
    bad_header(8'h21, "hdr21");

    // Full memory, back-to-back, then with bubbles
    do_reset();
    fill_random(32);
    st = cyc;
    load(32, 1'b0, dc);
    check_load("n32", 32, dc);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("n32_nostall", dc - st, 4*32 + 2);
`else
    chk("n32_nostall", dc - st, 4*32 + 1);
`endif
    ref_words.delete();
    foreach (obs_data[i]) ref_words.push_back(obs_data[i]);
    do_reset();
    load(32, 1'b1, dc);
    check_load("n32b", 32, dc);
    chk("n32b_same_count", obs_data.size(), ref_words.size());
    for (int i = 0; i < 32 && i < obs_data.size() && i < ref_words.size(); i++)
      chk($sformatf("n32b_same%0d", i), obs_data[i], ref_words[i]);

    // Reset mid-load
    do_reset();
    send(8'd2, 1'b0);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("mid_rdy", {31'd0, in_ready}, 32'd1);
    chk("mid_we", {31'd0, imem_we}, 32'd0);
    chk("mid_addr", 32'(imem_addr), 32'd0);
    chk("mid_wdata", imem_wdata, 32'd0);
    chk("mid_run", {31'd0, cpu_run}, 32'd0);
    chk("mid_err", {31'd0, error}, 32'd0);
    reset = 1'b1;
    obs_addr.delete();
    obs_data.delete();
    last_we_cyc = -1;
    run_cyc = -1;
    pl = {8'h12, 8'h34, 8'h56, 8'h78};
    load(1, 1'b0, dc);
    check_load("mid_n1", 1, dc);
    if (obs_data.size() == 1) chk("mid_n1_word", obs_data[0], 32'h12345678);

    // Reset while DONE, then a fresh load
    do_reset();
    chk("dr_run", {31'd0, cpu_run}, 32'd0);
    chk("dr_rdy", {31'd0, in_ready}, 32'd1);
    fill_random(3);
    load(3, 1'b1, dc);
    check_load("dr_n3", 3, dc);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong trailer
    do_reset();
    pl = {8'h12, 8'h34, 8'h56, 8'h78};
    send(8'd1, 1'b0);
    for (int i = 0; i < 4; i++) send(pl[i], 1'b0);
    send(8'h09, 1'b0);
    chk("cs_bad_err", {31'd0, error}, 32'd1);
    chk("cs_bad_rdy", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("cs_bad_run", {31'd0, cpu_run}, 32'd0);
    chk("cs_bad_wr", obs_addr.size(), 1);
`endif

    // Random loads
    repeat (4) begin
      do_reset();
      n = $urandom_range(1, SIZE);
      fill_random(n);
      load(n, 1'b1, dc);
      check_load($sformatf("rnd_n%0d", n), n, dc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
